// File: rtl/pattern_player_pkg.sv
// Shared state encoding, default parameters and the Morse preload for the pattern player.
// PATTERN_PLAYER_AUTOSTART_EN selects the Morse preload and autoplay; no flow control lives here.
package pattern_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int          DEF_WIDTH    = 16;
  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_DIV_W    = 24;
  localparam logic [23:0] DEF_AUTO_DIV = 24'd1999997;

  // Bit i of the word lands on bit 0 of RAM address i.
  localparam int                    MORSE_LEN  = 27;
  localparam logic [MORSE_LEN-1:0]  MORSE_WORD = 27'b101010001110111011100010101;

endpackage

// File: rtl/pattern_ram.sv
// Simple dual-port pattern RAM, one write port and one registered read port (maps to SB_RAM256x16 at defaults).
// Read data valid one cycle after rd_en; write port never stalls. PATTERN_PLAYER_AUTOSTART_EN preloads Morse.
module pattern_ram
  import pattern_player_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

`ifdef PATTERN_PLAYER_AUTOSTART_EN
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = '0;
    end
    for (int i = 0; i < MORSE_LEN; i++) begin
      mem[i][0] = MORSE_WORD[i];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bram_pattern_player.sv
// Plays an address window of the pattern RAM onto pat_out, div+3 cycles per word, once or looped; first word 2 cycles after start.
// Write port and controls are never backpressured. PATTERN_PLAYER_AUTOSTART_EN: autoplay the Morse loop after reset.
module bram_pattern_player
  import pattern_player_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter int               DIV_W    = DEF_DIV_W,
  parameter logic [DIV_W-1:0] AUTO_DIV = DIV_W'(DEF_AUTO_DIV)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  div,
  input  logic              loop,
  output logic [WIDTH-1:0]  pat_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  rdata;

  logic              auto_go;
  logic              go;
  logic [ADDR_W-1:0] go_start, go_end;
  logic [DIV_W-1:0]  go_div;
  logic              go_loop;

`ifdef PATTERN_PLAYER_AUTOSTART_EN
  // High only on the first cycle after RST releases.
  always_ff @(posedge CLK) begin
    auto_go <= RST;
  end
`else
  assign auto_go = 1'b0;
`endif

  // An external start in the autostart cycle takes its own config.
  assign go       = start | auto_go;
  assign go_start = start ? start_addr : '0;
  assign go_end   = start ? end_addr   : ADDR_W'(MORSE_LEN - 1);
  assign go_div   = start ? div        : AUTO_DIV;
  assign go_loop  = start ? loop       : 1'b1;

  pattern_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (state_q == FETCH),
    .rd_addr (addr_q),
    .rd_data (rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    pat_d   = pat_q;
    done_d  = 1'b0;

    // Stop beats start; neither raises done.
    if (stop) begin
      state_d = IDLE;
    end else if (go) begin
      start_d = go_start;
      end_d   = go_end;
      div_d   = go_div;
      loop_d  = go_loop;
      addr_d  = go_start;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: state_d = LOAD;
        LOAD: begin
          pat_d   = rdata;
          cnt_d   = div_q;
          state_d = HOLD;
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
          end else if (addr_q != end_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_q) begin
            addr_d  = start_q;
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      pat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

  assign pat_out  = pat_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cur_addr = addr_q;

endmodule

// File: tb/tb_bram_pattern_player.sv
// Bench for bram_pattern_player: window table, hand-built corner sequences and random windows against an arithmetic timeline model.
// With PATTERN_PLAYER_AUTOSTART_EN defined it also checks the Morse autoplay.
module tb_bram_pattern_player;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 8;
  localparam int DIV_W  = 24;

  logic              CLK = 1'b0;
  logic              RST;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              start, stop, loop;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [DIV_W-1:0]  div;
  logic [WIDTH-1:0]  pat_out;
  logic              busy, done;
  logic [ADDR_W-1:0] cur_addr;

  always #5 CLK = ~CLK;

  bram_pattern_player #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .DIV_W    (DIV_W),
    .AUTO_DIV (24'd1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .div        (div),
    .loop       (loop),
    .pat_out    (pat_out),
    .busy       (busy),
    .done       (done),
    .cur_addr   (cur_addr)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0]  mem_m [256];
  logic [WIDTH-1:0]  exp_pat;
  logic [ADDR_W-1:0] exp_cur;

  typedef struct {
    logic [7:0]       s;
    logic [7:0]       e;
    int               dv;
    logic             lp;
    logic [3:0][15:0] w;
    int               n;
    int               eb;
    int               ed;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int win_len(input logic [7:0] s, input logic [7:0] e);
    logic [7:0] d;
    d = e - s;
    return int'(d) + 1;
  endfunction

  // Expected outputs j edges after the start edge: word k shows for cycles 2+k*step..; address k is fetched from j=k*step.
  task automatic model(input int j, input logic [7:0] s, input int nw, input int step, input logic lp,
                       input logic [WIDTH-1:0] prev, output logic [WIDTH-1:0] ep,
                       output logic [7:0] ec, output logic eb);
    int k, c;
    logic [7:0] a;
    eb = lp || (j < nw * step);
    if (j < 2) begin
      ep = prev;
    end else begin
      k = (j - 2) / step;
      if (lp) k = k % nw;
      else if (k > nw - 1) k = nw - 1;
      a  = s + 8'(k);
      ep = mem_m[a];
    end
    c = j / step;
    if (lp) c = c % nw;
    else if (c > nw - 1) c = nw - 1;
    ec = s + 8'(c);
  endtask

  task automatic wr(input logic [7:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    mem_m[a] = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic do_stop(input string nm);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_pat"}, 32'(pat_out), 32'(exp_pat));
    chk({nm, "_cur"}, 32'(cur_addr), 32'(exp_cur));
    chk({nm, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic play(input string nm, input logic [7:0] s, input logic [7:0] e, input int dv,
                      input logic lp, input int n, input int exp_busy, input int exp_done);
    int nw, step, busy_seen, done_seen;
    logic [WIDTH-1:0] prev, ep;
    logic [7:0] ec;
    logic eb;
    nw   = win_len(s, e);
    step = dv + 3;
    prev = exp_pat;
    busy_seen = 0;
    done_seen = 0;
    start = 1'b1; start_addr = s; end_addr = e; div = DIV_W'(dv); loop = lp;
    @(negedge CLK);
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      model(j, s, nw, step, lp, prev, ep, ec, eb);
      chk($sformatf("%s_pat_c%0d", nm, j), 32'(pat_out), 32'(ep));
      chk($sformatf("%s_busy_c%0d", nm, j), 32'(busy), 32'(eb));
      chk($sformatf("%s_cur_c%0d", nm, j), 32'(cur_addr), 32'(ec));
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) done_seen++;
      @(negedge CLK);
    end
    model(n, s, nw, step, lp, prev, ep, ec, eb);
    exp_pat = ep;
    exp_cur = ec;
    chk({nm, "_busy_cycles"}, 32'(busy_seen), 32'(exp_busy));
    chk({nm, "_done_pulses"}, 32'(done_seen), 32'(exp_done));
  endtask

  initial begin
    logic [7:0] rs;
    int rn, rdv, rcyc;
    logic rlp;

    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; start_addr = '0; end_addr = '0; div = '0; loop = 1'b0;
    exp_pat = '0;
    exp_cur = '0;

    vt[0] = '{s: 8'd0,   e: 8'd3, dv: 2, lp: 1'b0, w: {16'h0008, 16'h0004, 16'h0002, 16'h0001}, n: 25, eb: 20, ed: 1};
    vt[1] = '{s: 8'd254, e: 8'd1, dv: 0, lp: 1'b0, w: {16'hFF00, 16'h00FF, 16'h5555, 16'hAAAA}, n: 16, eb: 12, ed: 1};
    vt[2] = '{s: 8'd7,   e: 8'd7, dv: 5, lp: 1'b0, w: {16'h0, 16'h0, 16'h0, 16'h1234},         n: 12, eb: 8,  ed: 1};
    vt[3] = '{s: 8'd9,   e: 8'd9, dv: 0, lp: 1'b0, w: {16'h0, 16'h0, 16'h0, 16'hBEEF},         n: 6,  eb: 3,  ed: 1};
    vt[4] = '{s: 8'd0,   e: 8'd3, dv: 2, lp: 1'b1, w: {16'h0008, 16'h0004, 16'h0002, 16'h0001}, n: 50, eb: 50, ed: 0};

    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pat", 32'(pat_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cur", 32'(cur_addr), 32'd0);
    RST = 1'b0;

`ifdef PATTERN_PLAYER_AUTOSTART_EN
    begin
      logic [26:0] morse_v;
      morse_v = 27'b101010001110111011100010101;
      @(negedge CLK);
      for (int j = 0; j < 218; j++) begin
        chk($sformatf("auto_busy_c%0d", j), 32'(busy), 32'd1);
        if (j >= 2)
          chk($sformatf("auto_bit_c%0d", j), 32'(pat_out), 32'(morse_v[((j - 2) / 4) % 27]));
        @(negedge CLK);
      end
      exp_pat = 16'(morse_v[((218 - 2) / 4) % 27]);
      exp_cur = 8'((218 / 4) % 27);
      do_stop("auto_stop");
    end
`else
    @(negedge CLK);
    @(negedge CLK);
    chk("idle_after_rst_busy", 32'(busy), 32'd0);
`endif

    // Window table: once, wrap-around, single-word, div=0, looped.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < win_len(vt[i].s, vt[i].e); k++)
        wr(vt[i].s + 8'(k), vt[i].w[k]);
      play($sformatf("vec%0d", i), vt[i].s, vt[i].e, vt[i].dv, vt[i].lp, vt[i].n, vt[i].eb, vt[i].ed);
    end

    // Looping window aborted by stop; outputs freeze.
    do_stop("stop_loop");
    @(negedge CLK);
    @(negedge CLK);
    chk("stop_frozen_pat", 32'(pat_out), 32'(exp_pat));
    chk("stop_frozen_cur", 32'(cur_addr), 32'(exp_cur));

    // Restart mid-play with a new window.
    wr(8'd20, 16'h0011); wr(8'd21, 16'h0022); wr(8'd22, 16'h0033); wr(8'd23, 16'h0044);
    wr(8'd40, 16'h00A1); wr(8'd41, 16'h00B2);
    play("restart_a", 8'd20, 8'd23, 3, 1'b0, 7, 7, 0);
    play("restart_b", 8'd40, 8'd41, 1, 1'b0, 12, 8, 1);

    // Start and stop together while busy: stop wins, config is not taken.
    play("ss_pre", 8'd20, 8'd23, 1, 1'b1, 9, 9, 0);
    start = 1'b1; start_addr = 8'd40; end_addr = 8'd41; div = '0; loop = 1'b0;
    do_stop("start_stop");
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("start_stop_idle_c%0d", j), 32'({busy, done}), 32'd0);
      @(negedge CLK);
    end

    // Reset mid-HOLD, then replay data written before the reset.
    play("rst_pre", 8'd0, 8'd3, 4, 1'b1, 5, 5, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_pat", 32'(pat_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cur", 32'(cur_addr), 32'd0);
    RST = 1'b0;
    exp_pat = '0;
    exp_cur = '0;
    play("rst_post", 8'd0, 8'd3, 1, 1'b0, 19, 16, 1);

    // Random windows, data and rates.
    for (int it = 0; it < 20; it++) begin
      rs   = 8'($urandom);
      rn   = int'($urandom_range(1, 6));
      rdv  = int'($urandom_range(0, 3));
      rlp  = 1'($urandom);
      for (int k = 0; k < rn; k++)
        wr(rs + 8'(k), 16'($urandom));
      rcyc = rlp ? int'($urandom_range(4, 40)) : rn * (rdv + 3) + 2;
      play($sformatf("rnd%0d", it), rs, rs + 8'(rn - 1), rdv, rlp, rcyc,
           rlp ? rcyc : rn * (rdv + 3), rlp ? 0 : 1);
      if (rlp) do_stop($sformatf("rnd%0d_stop", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
